seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIG, default 8, number of multiplexed seven-segment digits (2..8).
REQ-002 SHALL have parameter DIG_CYC, default 50000, clock cycles each digit is lit (>=2).
REQ-003 SHALL have parameter BLANK_CYC, default 16, anti-ghosting cycles with all digits off between digits (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  scan enable; low turns the display off.
REQ-007 SHALL have port load_valid  input  1  new frame offered.
REQ-008 SHALL have port load_data  input  4*NUM_DIG  hex nibbles; nibble i = bits [4i+3:4i] = digit i.
REQ-009 SHALL have port load_blank  input  NUM_DIG  per-digit blank mask; 1 = digit never lit.
REQ-010 SHALL have port load_ready  output  1  pending buffer empty, load accepted.
REQ-011 SHALL have port digit_data  output  4  nibble to the shared hex-to-segment decoder.
REQ-012 SHALL have port an_n  output  NUM_DIG  digit enables, active-low, at most one low.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse at start of each frame.

Function
REQ-014 SHALL hold two frame buffers: pending (data, blank, full flag) and display (data, blank).
REQ-015 SHALL accept a load when load_valid && load_ready, writing pending and setting full next cycle.
REQ-016 SHALL drive load_ready = !pending_full, combinationally from the registered flag.
REQ-017 SHALL use FSM states OFF, GUARD, ON, plus digit index idx (0..NUM_DIG-1) and cycle counter cnt.
REQ-018 OFF: an_n all ones; idx=0; when en=1 -> GUARD, cnt=0.
REQ-019 GUARD: an_n all ones; digit_data = display nibble idx; after BLANK_CYC cycles -> ON, cnt=0.
REQ-020 ON: an_n bit idx low unless display blank bit idx=1 (then all ones); digit_data unchanged; after DIG_CYC cycles -> GUARD.
REQ-021 ON->GUARD SHALL increment idx, wrapping NUM_DIG-1 -> 0.
REQ-022 On every entry to GUARD with idx=0 (incl. OFF->GUARD), if pending_full: display<=pending, pending_full<=0 in that same edge.
REQ-023 frame_start SHALL pulse high exactly one cycle, the first GUARD cycle with idx=0.
REQ-024 Digit switch SHALL change buffers only at a frame boundary; no tearing mid-frame.
REQ-025 en=0 in any state SHALL force OFF on the next edge (anodes off that cycle), idx=0; pending contents and flag retained.
REQ-026 Load offered while pending_full SHALL be ignored (load_ready=0); producer holds load_valid.
REQ-027 Load accept and commit SHALL never collide: commit only when full, accept only when empty.
REQ-028 All outputs except load_ready SHALL be registered; an_n glitch-free.
REQ-029 cnt width SHALL be clog2(max(DIG_CYC,BLANK_CYC)); no overflow at boundaries.

Reset
REQ-030 On rst_n low, immediately: state=OFF, idx=0, cnt=0, an_n all ones, digit_data=0, frame_start=0, pending_full=0, load_ready=1.
REQ-031 Reset SHALL set display data to 0 and display blank to all ones (dark until first load).
REQ-032 Reset asserted mid-scan SHALL abort immediately; release resumes in OFF.

Verification (NUM_DIG=4, DIG_CYC=4, BLANK_CYC=2)
REQ-033 Reset, en=1, no load -> frame_start pulses every 24 cycles, an_n stays 4'b1111.
REQ-034 Load data=16'h3210, blank=0, en=1 -> per digit: 2 cycles 1111, then 4 cycles 1110/1101/1011/0111 with digit_data 0,1,2,3.
REQ-035 Second load mid-frame -> accepted, load_ready=0 until next frame_start cycle, then displayed; third load stalls meanwhile.
REQ-036 blank=4'b0100 -> digit 2 slot shows an_n=1111 for 4 cycles, timing unchanged.
REQ-037 en dropped during ON of digit 2 -> next cycle an_n=1111, state OFF; en restored -> scan restarts at digit 0 with frame_start.
REQ-038 rst_n pulsed low during ON -> an_n=1111 same cycle, load_ready=1, display dark after release.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered frame.
// A new frame is committed only at a frame boundary, so a frame never tears mid-scan.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_OFF   | display dark, idx held at 0, waits for en
//   ST_GUARD | anti-ghosting gap, all anodes off, nibble idx presented
//   ST_ON    | digit idx lit (unless blanked) for DIG_CYC cycles
module seg_scan_ctrl #(
    parameter int NUM_DIG   = 8,
    parameter int DIG_CYC   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   load_valid,
    input  logic [4*NUM_DIG-1:0]   load_data,
    input  logic [NUM_DIG-1:0]     load_blank,
    output logic                   load_ready,
    output logic [3:0]             digit_data,
    output logic [NUM_DIG-1:0]     an_n,
    output logic                   frame_start
);

    localparam int CNT_MAX = (DIG_CYC > BLANK_CYC) ? DIG_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = $clog2(NUM_DIG);

    localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(DIG_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 pend_full_q;
    logic [4*NUM_DIG-1:0] pend_data_q;
    logic [NUM_DIG-1:0]   pend_blank_q;
    logic [4*NUM_DIG-1:0] disp_data_q, disp_data_d;
    logic [NUM_DIG-1:0]   disp_blank_q, disp_blank_d;

    logic                 enter_frame;
    logic                 commit;
    logic                 accept;
    logic [3:0]           digit_data_d;
    logic [NUM_DIG-1:0]   an_n_d;

    assign load_ready = !pend_full_q;
    assign accept     = load_valid && !pend_full_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        enter_frame = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d     = ST_GUARD;
                    idx_d       = '0;
                    cnt_d       = '0;
                    enter_frame = 1'b1;
                end
                ST_GUARD: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt_q == DIG_LAST) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d       = '0;
                            enter_frame = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Commit needs a full pending buffer and accept needs an empty one, so they never collide.
    assign commit = enter_frame && pend_full_q;

    always_comb begin
        disp_data_d  = disp_data_q;
        disp_blank_d = disp_blank_q;
        if (commit) begin
            disp_data_d  = pend_data_q;
            disp_blank_d = pend_blank_q;
        end
    end

    // Outputs are derived from next-state values so the registered copies line up with the state.
    always_comb begin
        digit_data_d = disp_data_d[{idx_d, 2'b00} +: 4];
        an_n_d       = '1;
        if (state_d == ST_ON && !disp_blank_d[idx_d]) begin
            an_n_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            an_n        <= '1;
            digit_data  <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            an_n        <= an_n_d;
            digit_data  <= digit_data_d;
            frame_start <= enter_frame;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_q  <= 1'b0;
            pend_data_q  <= '0;
            pend_blank_q <= '1;
            disp_data_q  <= '0;
            disp_blank_q <= '1;
        end else begin
            disp_data_q  <= disp_data_d;
            disp_blank_q <= disp_blank_d;
            if (commit) begin
                pend_full_q <= 1'b0;
            end else if (accept) begin
                pend_full_q  <= 1'b1;
                pend_data_q  <= load_data;
                pend_blank_q <= load_blank;
            end
        end
    end

endmodule
